// File: rtl/mux_t_be_t_n.sv
// Multi-channel race-logic mux: each channel picks one edge-coded input per gamma cycle,
// re-emits its first rising edge and reports the edge time. Optional build macro: MUX_PULSE_OUT_EN.
module mux_t_be_t_n #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = GAMMA_CYCLE_WIDTH,
    parameter int NUM_CHANNELS      = 4,
    parameter int SELECT_WIDTH      = $clog2(NUM_INPUTS),
    parameter int TIME_WIDTH        = $clog2(GAMMA_CYCLE_WIDTH + 1)
) (
    input  logic                                 aclk,
    input  logic                                 grst_n,
    input  logic                                 gamma_start,
    input  logic [NUM_INPUTS-1:0]                inputs,
    input  logic [NUM_CHANNELS*SELECT_WIDTH-1:0] select,
    output logic [NUM_CHANNELS-1:0]              out,
    output logic [NUM_CHANNELS*TIME_WIDTH-1:0]   out_time,
    output logic                                 out_valid,
    output logic                                 busy
);

    localparam int SEL_SPAN = 1 << SELECT_WIDTH;
    localparam logic [TIME_WIDTH-1:0] TIME_INF = TIME_WIDTH'(GAMMA_CYCLE_WIDTH);

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ARMED,
        CH_FIRED
    } ch_state_t;

    logic [TIME_WIDTH-1:0] tick_reg;
    logic                  busy_reg;
    logic                  out_valid_reg;
    logic                  close_evt;
    logic                  sample_evt;
    logic [SEL_SPAN-1:0]   inputs_pad;

    // Out-of-range selects land on the zero padding, so such channels never fire.
    assign inputs_pad = SEL_SPAN'(inputs);

    // tick reaching GAMMA_CYCLE_WIDTH marks the close edge that follows the last sample.
    assign close_evt  = busy_reg && (gamma_start || (tick_reg == TIME_INF));
    assign sample_evt = busy_reg && !gamma_start && (tick_reg != TIME_INF);

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            tick_reg      <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= close_evt;
            if (gamma_start) begin
                tick_reg <= '0;
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                if (tick_reg == TIME_INF) begin
                    busy_reg <= 1'b0;
                end else begin
                    tick_reg <= tick_reg + TIME_WIDTH'(1);
                end
            end
        end
    end

    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            ch_state_t               state_reg;
            ch_state_t               state_next;
            logic [SELECT_WIDTH-1:0] sel_reg;
            logic [TIME_WIDTH-1:0]   cap_reg;
            logic [TIME_WIDTH-1:0]   time_reg;
            logic                    out_reg;
            logic                    fire;

            always_comb begin
                state_next = state_reg;
                fire       = 1'b0;
                if (gamma_start) begin
                    state_next = CH_ARMED;
                end else begin
                    case (state_reg)
                        CH_ARMED: begin
                            if (close_evt) begin
                                state_next = CH_IDLE;
                            end else if (sample_evt && inputs_pad[sel_reg]) begin
                                state_next = CH_FIRED;
                                fire       = 1'b1;
                            end
                        end
                        CH_FIRED: begin
                            if (close_evt) begin
                                state_next = CH_IDLE;
                            end
                        end
                        default: state_next = state_reg;
                    endcase
                end
            end

            // cap_reg starts at INF each cycle, so publishing it on close covers unfired channels.
            always_ff @(posedge aclk or negedge grst_n) begin
                if (!grst_n) begin
                    state_reg <= CH_IDLE;
                    sel_reg   <= '0;
                    cap_reg   <= TIME_INF;
                    time_reg  <= TIME_INF;
                end else begin
                    state_reg <= state_next;
                    if (close_evt) begin
                        time_reg <= cap_reg;
                    end
                    if (gamma_start) begin
                        sel_reg <= select[gi*SELECT_WIDTH +: SELECT_WIDTH];
                        cap_reg <= TIME_INF;
                    end else if (fire) begin
                        cap_reg <= tick_reg;
                    end
                end
            end

`ifdef MUX_PULSE_OUT_EN
            localparam int PCW = $clog2(PULSE_WIDTH + 1);
            logic [PCW-1:0] pulse_cnt_reg;

            always_ff @(posedge aclk or negedge grst_n) begin
                if (!grst_n) begin
                    out_reg       <= 1'b0;
                    pulse_cnt_reg <= '0;
                end else if (gamma_start) begin
                    out_reg       <= 1'b0;
                    pulse_cnt_reg <= '0;
                end else if (fire) begin
                    out_reg       <= 1'b1;
                    pulse_cnt_reg <= PCW'(PULSE_WIDTH - 1);
                end else if (out_reg) begin
                    if (pulse_cnt_reg == '0) begin
                        out_reg <= 1'b0;
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg - PCW'(1);
                    end
                end
            end
`else
            always_ff @(posedge aclk or negedge grst_n) begin
                if (!grst_n) begin
                    out_reg <= 1'b0;
                end else if (gamma_start) begin
                    out_reg <= 1'b0;
                end else if (fire) begin
                    out_reg <= 1'b1;
                end
            end
`endif

            assign out[gi]                             = out_reg;
            assign out_time[gi*TIME_WIDTH +: TIME_WIDTH] = time_reg;
        end
    endgenerate

endmodule

// File: tb/tb_mux_t_be_t_n.sv
// Scoreboard bench for mux_t_be_t_n: per-cycle expected edge times are queued when a cycle's
// stimulus has been driven and compared when out_valid strobes.
module tb_mux_t_be_t_n;

    localparam int GCW = 16;
    localparam int PW  = 8;
    localparam int NI  = 16;
    localparam int NC  = 4;
    localparam int SW  = 4;
    localparam int TW  = 5;
    localparam logic [NC*TW-1:0] ALL_INF = {NC{5'd16}};

    logic              aclk = 1'b0;
    logic              grst_n = 1'b0;
    logic              gamma_start = 1'b0;
    logic [NI-1:0]     inputs = '0;
    logic [NC*SW-1:0]  select = '0;
    logic [NC-1:0]     out;
    logic [NC*TW-1:0]  out_time;
    logic              out_valid;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [NC*TW-1:0] exp_q[$];
    logic [NI-1:0]    wave[GCW];
    logic [NC*SW-1:0] cur_sel;
    int               fire_t[NC];

    mux_t_be_t_n #(
        .GAMMA_CYCLE_WIDTH(GCW),
        .PULSE_WIDTH(PW),
        .NUM_INPUTS(NI),
        .NUM_CHANNELS(NC)
    ) dut (
        .aclk(aclk),
        .grst_n(grst_n),
        .gamma_start(gamma_start),
        .inputs(inputs),
        .select(select),
        .out(out),
        .out_time(out_time),
        .out_valid(out_valid),
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic exp_out(input int f, input int t);
        if (f < 0) return 1'b0;
`ifdef MUX_PULSE_OUT_EN
        return (t - f) < PW;
`else
        return t >= f;
`endif
    endfunction

    always @(negedge aclk) begin
        logic [NC*TW-1:0] e;
        if (grst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("close: out_time=%h expected=%h", out_time, e);
                for (int k = 0; k < NC; k++)
                    check_eq($sformatf("out_time_ch%0d", k), 32'(out_time[k*TW +: TW]), 32'(e[k*TW +: TW]));
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_wave();
        for (int t = 0; t < GCW; t++) wave[t] = '0;
    endtask

    task automatic rise_at(input int line, input int t0);
        for (int t = 0; t < GCW; t++) if (t >= t0) wave[t][line] = 1'b1;
    endtask

    task automatic open_cycle(input logic [NC*SW-1:0] sel_pk);
        cur_sel     = sel_pk;
        select      = sel_pk;
        inputs      = wave[0];
        gamma_start = 1'b1;
        step();
        gamma_start = 1'b0;
        for (int k = 0; k < NC; k++) fire_t[k] = -1;
        check_eq("busy_open", 32'(busy), 32'd1);
        check_eq("out_open", 32'(out), 32'd0);
    endtask

    task automatic do_ticks(input int n);
        logic [NC-1:0] eo;
        int s;
        for (int t = 0; t < n; t++) begin
            inputs = wave[t];
            select = 16'($urandom);
            step();
            for (int k = 0; k < NC; k++) begin
                s = int'(cur_sel[k*SW +: SW]);
                if (fire_t[k] < 0 && s < NI && wave[t][s]) fire_t[k] = t;
                eo[k] = exp_out(fire_t[k], t);
            end
            check_eq($sformatf("out_t%0d", t), 32'(out), 32'(eo));
        end
    endtask

    task automatic push_expected();
        logic [NC*TW-1:0] e;
        for (int k = 0; k < NC; k++)
            e[k*TW +: TW] = (fire_t[k] < 0) ? 5'd16 : 5'(fire_t[k]);
        exp_q.push_back(e);
    endtask

    task automatic close_normal();
        logic [NC-1:0] eo;
        for (int t = GCW; t < GCW + 3; t++) begin
            step();
            for (int k = 0; k < NC; k++) eo[k] = exp_out(fire_t[k], t);
            check_eq("out_after_close", 32'(out), 32'(eo));
            check_eq("busy_after_close", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int line;
        clear_wave();
        #12;
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_time", 32'(out_time), 32'(ALL_INF));
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        step();
        grst_n = 1'b1;
        step();

        // ch0 sel 3, line 3 rises at tick 5
        clear_wave(); rise_at(3, 5);
        open_cycle({4'd9, 4'd9, 4'd9, 4'd3});
        do_ticks(GCW); push_expected(); close_normal();

        // shared select, two lines, one never rising
        clear_wave(); rise_at(0, 2); rise_at(7, 9);
        open_cycle({4'd15, 4'd7, 4'd0, 4'd0});
        do_ticks(GCW); push_expected(); close_normal();

        // line already high before opening, then toggled
        clear_wave(); rise_at(4, 0);
        for (int t = 5; t < 8; t++) wave[t][4] = 1'b0;
        open_cycle({4'd2, 4'd4, 4'd4, 4'd4});
        do_ticks(GCW); push_expected(); close_normal();

        // truncated after 6 samples
        clear_wave(); rise_at(3, 3);
        open_cycle({4'd12, 4'd11, 4'd10, 4'd3});
        do_ticks(6); push_expected();

        // opened by truncation; line 10 high on that edge must not fire the old ch1
        clear_wave(); rise_at(2, 2); rise_at(6, 12); rise_at(10, 0);
        open_cycle({4'd15, 4'd10, 4'd6, 4'd2});
        do_ticks(14); push_expected();

        // truncation close, then reset mid-cycle
        clear_wave(); rise_at(1, 1);
        open_cycle({4'd13, 4'd13, 4'd13, 4'd1});
        do_ticks(7);
        #2;
        grst_n = 1'b0;
        #1;
        check_eq("midrst_out", 32'(out), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_time", 32'(out_time), 32'(ALL_INF));
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        step(); step();
        grst_n = 1'b1;
        step(); step();
        check_eq("post_rst_valid", 32'(out_valid), 32'd0);

        for (int c = 0; c < 3; c++) begin
            clear_wave();
            for (int k = 0; k < NC; k++) begin
                line = int'($urandom_range(0, NI - 1));
                rise_at(line, int'($urandom_range(0, 20)));
            end
            open_cycle(16'($urandom));
            do_ticks(GCW); push_expected(); close_normal();
        end

        step(); step();
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
